// File: rtl/log_pkg.sv
// Shared log-domain constants: Q-format widths and the 8-segment Mitchell correction table.
package log_pkg;

  localparam int FRAC_IN  = 12;
  localparam int FRAC_OUT = 12;
  localparam int LOG_W    = 17;

  // Mitchell error log2(1+x) - x at each segment midpoint, Q0.12
  function automatic logic [11:0] corr_lookup(input logic [2:0] seg);
    logic [11:0] c;
    case (seg)
      3'd0:    c = 12'd102;
      3'd1:    c = 12'd248;
      3'd2:    c = 12'd327;
      3'd3:    c = 12'd352;
      3'd4:    c = 12'd333;
      3'd5:    c = 12'd276;
      3'd6:    c = 12'd186;
      3'd7:    c = 12'd68;
      default: c = 12'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/log_lod.sv
// Combinational leading-one detector: k is the index of the highest set bit of m.
module log_lod #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         m,
  output logic [$clog2(WIDTH)-1:0] k,
  output logic                     zero
);

  localparam int KW = $clog2(WIDTH);

  // Scan upward so the last set bit seen wins
  always_comb begin
    k    = '0;
    zero = (m == '0);
    for (int i = 0; i < WIDTH; i++) begin
      k = m[i] ? KW'(i) : k;
    end
  end

endmodule

// File: rtl/lin2log_converter.sv
// Signed linear sample to sign/magnitude Q4.12 log2, three pipeline stages under one global stall.
module lin2log_converter
  import log_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC_IN  = log_pkg::FRAC_IN,
  parameter int FRAC_OUT = log_pkg::FRAC_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   log_out,
  output logic             log_valid,
  output logic             sign_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int KW = $clog2(WIDTH);
  localparam int OW = WIDTH + 1;
  localparam int SW = WIDTH + 2;

  logic                  adv;
  logic                  v1, v2;
  logic                  s1_sign, s2_sign, s2_zero;
  logic [WIDTH-1:0]      s1_mag, mag;
  logic [KW-1:0]         lod_k, shamt;
  logic                  lod_zero;
  logic [WIDTH-1:0]      norm;
  logic [FRAC_OUT-1:0]   frac, s2_f;
  logic signed [KW:0]    expo, s2_e;
  logic [11:0]           corr;
  logic signed [SW-1:0]  sum;
  logic [OW-1:0]         sat;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // S1: two's-complement magnitude; the most negative input maps to 2^(WIDTH-1) unsigned
  assign mag = in_data[WIDTH-1] ? (~in_data + {{(WIDTH-1){1'b0}}, 1'b1}) : in_data;

  log_lod #(.WIDTH(WIDTH)) u_lod (
    .m    (s1_mag),
    .k    (lod_k),
    .zero (lod_zero)
  );

  // S2: normalise to the MSB; the cast drops the leading one, leaving the fraction
  assign shamt = KW'(WIDTH - 1) - lod_k;
  assign norm  = s1_mag << shamt;
  assign frac  = FRAC_OUT'(norm >> (WIDTH - 1 - FRAC_OUT));
  assign expo  = $signed({1'b0, lod_k}) - $signed((KW + 1)'(FRAC_IN));

  // S3: Mitchell estimate plus segment correction, saturated to the output range
  assign corr = (s2_f == '0) ? 12'd0 : corr_lookup(s2_f[FRAC_OUT-1 -: 3]);
  assign sum  = (SW'(s2_e) <<< FRAC_OUT)
              + $signed(SW'({1'b0, s2_f}))
              + $signed(SW'({1'b0, corr}));
  assign sat  = (sum[SW-1] != sum[SW-2])
              ? (sum[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
              : sum[OW-1:0];

  // Pipeline registers: all stages advance together or hold together
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1        <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_e      <= '0;
      s2_f      <= '0;
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      log_valid <= 1'b0;
      log_out   <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      s1_sign   <= in_data[WIDTH-1];
      s1_mag    <= mag;
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_zero   <= lod_zero;
      s2_e      <= expo;
      s2_f      <= frac;
      out_valid <= v2;
      sign_out  <= s2_sign;
      log_valid <= ~s2_zero;
      log_out   <= s2_zero ? '0 : sat;
    end
  end

endmodule

// File: tb/tb_lin2log_converter.sv
// Directed and randomized checks of lin2log_converter against an arithmetic log2 reference.
module tb_lin2log_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] log_out;
  logic        log_valid;
  logic        sign_out;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  lin2log_converter dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .log_out   (log_out),
    .log_valid (log_valid),
    .sign_out  (sign_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [18:0] exp;
    int          t;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  bit          acc;
  bit          stall_prev = 1'b0;
  bit          lat_mode = 1'b1;
  logic [19:0] held;
  int          corr_tab [8] = '{102, 248, 327, 352, 333, 276, 186, 68};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: log2 from integer arithmetic, packed as {sign, log_valid, log[16:0]}
  function automatic logic [18:0] model(input logic [15:0] d);
    int v, m, k, f, c, lg;
    logic [16:0] l17;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    if (m == 0) return {d[15], 1'b0, 17'd0};
    k = 0;
    while ((1 << (k + 1)) <= m) k++;
    f  = ((m * 4096) >> k) - 4096;
    c  = (f == 0) ? 0 : corr_tab[f / 512];
    lg = (k - 12) * 4096 + f + c;
    if (lg > 65535) lg = 65535;
    if (lg < -65536) lg = -65536;
    l17 = lg[16:0];
    return {d[15], 1'b1, l17};
  endfunction

  task automatic step(input logic v, input logic [15:0] d, input logic r,
                      input bit hx = 1'b0, input logic [18:0] x = 19'd0);
    ent_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (stall_prev) check("hold", {out_valid, sign_out, log_valid, log_out}, held);
    if (out_valid && !out_ready) begin
      check("stall_in_ready", in_ready, 1'b0);
      held       = {out_valid, sign_out, log_valid, log_out};
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("out", {sign_out, log_valid, log_out}, e.exp);
        if (lat_mode) check("latency", cyc - e.t, 3);
      end
    end
    @(posedge clk);
    if (acc) begin
      e.exp = hx ? x : model(d);
      e.t   = cyc;
      q.push_back(e);
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      step(1'b0, 16'd0, 1'b1);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic stream(input int count, input bit specials);
    int          sent = 0;
    int          guard = 0;
    logic [15:0] cur;
    cur = 16'($urandom);
    while (sent < count && guard < 2000) begin
      step(1'b1, cur, 1'($urandom_range(0, 1)));
      if (acc) begin
        sent++;
        cur = 16'($urandom);
        if (specials && $urandom_range(0, 9) == 0) cur = 16'h0000;
        if (specials && $urandom_range(0, 19) == 0) cur = 16'h8000;
      end
      guard++;
    end
    check("stream_sent", sent, count);
    drain();
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {sign_out, log_valid, log_out}, 19'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b1;

    // Back-to-back powers of two, including a negative one
    step(1'b1, 16'd4096, 1'b1, 1'b1, {1'b0, 1'b1, 17'd0});
    step(1'b1, 16'd8192, 1'b1, 1'b1, {1'b0, 1'b1, 17'd4096});
    step(1'b1, 16'hC000, 1'b1, 1'b1, {1'b1, 1'b1, 17'd8192});
    // Zero, smallest magnitude, most negative
    step(1'b1, 16'd0,    1'b1, 1'b1, {1'b0, 1'b0, 17'd0});
    step(1'b1, 16'd1,    1'b1, 1'b1, {1'b0, 1'b1, 17'h14000});
    step(1'b1, 16'h8000, 1'b1, 1'b1, {1'b1, 1'b1, 17'd12288});
    // Largest positive and a mid-segment fraction
    step(1'b1, 16'd32767, 1'b1, 1'b1, {1'b0, 1'b1, 17'd12355});
    step(1'b1, 16'd6144,  1'b1, 1'b1, {1'b0, 1'b1, 17'd2381});
    drain();

    lat_mode = 1'b0;
    stream(10, 1'b0);
    stream(150, 1'b1);

    // Reset with two samples in flight
    step(1'b1, 16'd1234, 1'b1);
    step(1'b1, 16'd4321, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_outputs", {sign_out, log_valid, log_out}, 19'd0);
    check("flush_in_ready", in_ready, 1'b1);
    q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'd0, 1'b1);
      check("flushed", out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
